bus_initiator: RTL and testbench

BUS_INITIATOR -- requirements
Module: bus_initiator

---
 rtl/bus_initiator.sv | 182 ++++++++++++++++++
 tb/tb_bus_initiator.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_initiator.sv
// -----------------------------------------------------------------------------
// bus_initiator
//
// Queues read/write commands in a small FIFO and replays them one at a time on
// a simple chip-select bus. Each transaction drives bus_cs for one cycle.
// Writes complete silently. Reads wait for the responder's data, capture it
// into a response register and hold it there until the consumer takes it.
//
// Parameters
//   CMD_DEPTH     command FIFO entries (power of 2, >= 2)
//   READ_LATENCY  edges from the end of the cs cycle to bus_rdata valid (1..3)
//
// Ports
//   clk, rst                   clock and synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_we/cmd_addr/cmd_wdata  command payload (1=write; wdata unused on reads)
//   bus_cs/bus_we/bus_addr     bus transaction outputs (held when bus_cs=0)
//   bus_wdata                  bus write data
//   bus_rdata                  responder read data
//   rsp_valid/rsp_ready        read-response handshake
//   rsp_data/rsp_addr          captured read data and its address
//   busy                       FIFO non-empty or a transaction in flight
//   txn_count                  bus transactions issued, wraps at 16 bits
//
// Build option
//   BUS_INIT_TRACE_EN  when defined, prints one trace line per issued
//                      transaction and one per captured read.
// -----------------------------------------------------------------------------
module bus_initiator #(
  parameter int CMD_DEPTH    = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic        busy,
  output logic [15:0] txn_count
);

  localparam int          AW         = $clog2(CMD_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(CMD_DEPTH);
  localparam logic [1:0]  WAIT_INIT  = 2'(READ_LATENCY - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    wait_cnt;
  logic [64:0]   fifo_mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [64:0]   head;

  // Status decoding. cmd_ready depends only on the registered count, so a pop
  // on the same edge can never make room for a push into a full FIFO.
  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_IDLE) && !empty;
  assign head      = fifo_mem[rd_ptr];
  assign busy      = !empty || (state != ST_IDLE);

  // FIFO storage: entries are {we, addr, wdata}. No reset needed because the
  // pointers and count decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {cmd_we, cmd_addr, cmd_wdata};
  end

  // FIFO pointers and occupancy. An entry pushed into an empty FIFO only
  // becomes visible to the FSM through count on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Transaction sequencer. IDLE pops and loads the bus registers, ISSUE is the
  // single bus_cs cycle, WAIT counts down the remaining read latency and
  // captures bus_rdata on its final edge, RESP holds the result until taken.
  // Returning to IDLE before the next pop guarantees bus_cs never repeats on
  // consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      bus_cs    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      txn_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            bus_cs    <= 1'b1;
            bus_we    <= head[64];
            bus_addr  <= head[63:32];
            bus_wdata <= head[31:0];
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bus_cs    <= 1'b0;
          txn_count <= txn_count + 16'd1;
          if (bus_we) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            rsp_data  <= bus_rdata;
            rsp_addr  <= bus_addr;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BUS_INIT_TRACE_EN
  // Simulation trace: one line per bus_cs cycle, one per captured read.
  always_ff @(posedge clk) begin
    if (!rst && bus_cs)
      $display("[BUS-INIT] %s Addr: %h Data: %h", bus_we ? "WR" : "RD",
               bus_addr, bus_wdata);
    if (!rst && state == ST_WAIT && wait_cnt == 2'd0)
      $display("[BUS-INIT] RD Addr: %h Data: %h", bus_addr, bus_rdata);
  end
`else
  // Trace disabled: no simulation output, identical cycle behaviour.
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_bus_initiator
//
// Scoreboard bench for bus_initiator. Stimulus pushes the expected bus
// transaction, and for reads the expected response, into queues when a command
// is accepted. A memory model computes the read data: writes update it in
// command order and reads return its contents. A monitor process, running on
// the falling edge, acts as the bus responder and response consumer. It pops
// and compares whenever the DUT shows bus_cs or completes a response handshake.
// -----------------------------------------------------------------------------
module tb_bus_initiator;

  localparam int DEPTH = 4;
  localparam int RL    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        bus_cs;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [31:0] rsp_addr;
  logic        busy;
  logic [15:0] txn_count;

  always #5 clk = ~clk;

  bus_initiator #(.CMD_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .busy(busy), .txn_count(txn_count)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } bus_txn_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } rsp_txn_t;

  bus_txn_t    exp_bus[$];
  rsp_txn_t    exp_rsp[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] resp_mem  [logic [31:0]];

  int          check_count = 0;
  int          error_count = 0;
  int          rsp_mode = 0;
  bit          txn_check_en = 1'b1;
  logic [15:0] model_txn = '0;
  int          cycle = 0;
  int          last_read_cycle = 0;

  bit          prev_cs = 1'b0;
  logic        last_we = 1'b0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  bit          prev_valid = 1'b0;
  bit          prev_ready = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] prev_addr = '0;
  bit          hist_v [4];
  logic [31:0] hist_d [4];

  // Unwritten memory locations read back as a fixed scramble of the address.
  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic failEvent(input string name);
    check_count++;
    error_count++;
    $display("[TB] FAIL %s (event not allowed here)", name);
  endtask

  // Offers one command and waits, bounded, for it to be accepted. The expected
  // bus transaction and read response are recorded at acceptance.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int budget = 100;
    bus_txn_t b;
    rsp_txn_t r;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    while (!cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!cmd_ready) begin
      failEvent("cmd_accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    b.we = we; b.addr = addr; b.wdata = wdata;
    exp_bus.push_back(b);
    if (we) begin
      model_mem[addr] = wdata;
    end else begin
      r.addr = addr;
      r.data = model_mem.exists(addr) ? model_mem[addr] : default_word(addr);
      exp_rsp.push_back(r);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int budget = 400;
    while ((busy || rsp_valid || exp_bus.size() != 0 || exp_rsp.size() != 0)
           && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) failEvent("drain_timeout");
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h4000_0100 + (32'($urandom_range(0, 15)) << 2);
  endfunction

  // Monitor, responder and consumer, all on the falling edge so every DUT
  // output is stable when sampled.
  always @(negedge clk) begin
    bus_txn_t e;
    rsp_txn_t r;
    cycle++;
    if (rst) begin
      exp_bus.delete();
      exp_rsp.delete();
      model_txn  = '0;
      prev_cs    = 1'b0;
      last_we    = 1'b0;
      last_addr  = '0;
      last_wdata = '0;
      prev_valid = 1'b0;
      for (int i = 0; i < 4; i++) hist_v[i] = 1'b0;
      bus_rdata = $urandom;
    end else begin
      if (txn_check_en) checkOutput("txn_count", txn_count, model_txn);
      if (bus_cs) begin
        if (prev_cs) failEvent("cs_back_to_back");
        if (rsp_valid) failEvent("cs_while_rsp_pending");
        if (exp_bus.size() == 0) begin
          failEvent("unexpected_cs");
        end else begin
          e = exp_bus.pop_front();
          checkOutput("bus_we", bus_we, e.we);
          checkOutput("bus_addr", bus_addr, e.addr);
          checkOutput("bus_wdata", bus_wdata, e.wdata);
        end
        last_we    = bus_we;
        last_addr  = bus_addr;
        last_wdata = bus_wdata;
        model_txn++;
        if (!bus_we) last_read_cycle = cycle;
      end else begin
        checkOutput("bus_we_hold", bus_we, last_we);
        checkOutput("bus_addr_hold", bus_addr, last_addr);
        checkOutput("bus_wdata_hold", bus_wdata, last_wdata);
      end
      prev_cs = bus_cs;

      // Responder: data for a read issued in cycle c is valid in cycle c+RL.
      if (bus_cs && bus_we) resp_mem[bus_addr] = bus_wdata;
      for (int i = 3; i > 0; i--) begin
        hist_v[i] = hist_v[i-1];
        hist_d[i] = hist_d[i-1];
      end
      hist_v[0] = bus_cs && !bus_we;
      hist_d[0] = resp_mem.exists(bus_addr) ? resp_mem[bus_addr]
                                            : default_word(bus_addr);
      bus_rdata = hist_v[RL] ? hist_d[RL] : $urandom;
    end

    // Consumer: choose rsp_ready for the coming edge.
    case (rsp_mode)
      0:       rsp_ready = ($urandom_range(0, 3) != 0);
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'b1;
    endcase

    if (!rst) begin
      if (prev_valid && !prev_ready) begin
        checkOutput("rsp_valid_held", rsp_valid, 1'b1);
        checkOutput("rsp_data_held", rsp_data, prev_data);
        checkOutput("rsp_addr_held", rsp_addr, prev_addr);
      end
      if (rsp_valid && !prev_valid)
        checkOutput("rsp_latency", cycle, last_read_cycle + RL + 1);
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          failEvent("unexpected_rsp");
        end else begin
          r = exp_rsp.pop_front();
          checkOutput("rsp_addr", rsp_addr, r.addr);
          checkOutput("rsp_data", rsp_data, r.data);
        end
      end
      prev_valid = rsp_valid;
      prev_ready = rsp_ready;
      prev_data  = rsp_data;
      prev_addr  = rsp_addr;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int budget;
    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", cmd_ready, 1'b0);
    checkOutput("reset_bus_cs", bus_cs, 1'b0);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_txn_count", txn_count, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Single write: one cs cycle, no response, count of one.
    applyStimulus(1'b1, 32'h4000_0004, 32'hDEAD_BEEF);
    waitIdle();
    checkOutput("txn_after_write", txn_count, 16'h0001);

    // Single read with a known memory word.
    model_mem[32'h4000_0008] = 32'h1234_5678;
    resp_mem[32'h4000_0008]  = 32'h1234_5678;
    applyStimulus(1'b0, 32'h4000_0008, 32'h0);
    waitIdle();
    checkOutput("txn_after_read", txn_count, 16'h0002);

    // Stalled response with a full FIFO behind it.
    rsp_mode = 1;
    applyStimulus(1'b0, 32'h4000_0010, 32'h0);
    budget = 50;
    while (!rsp_valid && budget > 0) begin @(negedge clk); budget--; end
    if (!rsp_valid) failEvent("rsp_wait_timeout");
    applyStimulus(1'b1, 32'h4000_0010, 32'hA0A0_0001);
    applyStimulus(1'b0, 32'h4000_0010, 32'h0);
    applyStimulus(1'b1, 32'h4000_0014, 32'hA0A0_0002);
    applyStimulus(1'b0, 32'h4000_0014, 32'h0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("cmd_ready_full", cmd_ready, 1'b0);
      @(negedge clk);
    end
    rsp_mode = 2;
    applyStimulus(1'b1, 32'h4000_0018, 32'hA0A0_0003);
    rsp_mode = 0;
    waitIdle();

    // Randomized traffic with random consumer back-pressure.
    for (int n = 0; n < 150; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), rand_addr(), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitIdle();

    // Reset while a read is waiting for data; a queued command is dropped.
    applyStimulus(1'b0, 32'h4000_0020, 32'h0);
    applyStimulus(1'b0, 32'h4000_0024, 32'h0);
    budget = 20;
    while (!(bus_cs && !bus_we) && budget > 0) begin @(negedge clk); budget--; end
    if (budget == 0) failEvent("read_issue_timeout");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_wait_bus_cs", bus_cs, 1'b0);
    checkOutput("rst_wait_rsp_valid", rsp_valid, 1'b0);
    checkOutput("rst_wait_busy", busy, 1'b0);
    checkOutput("rst_wait_txn_count", txn_count, 16'h0000);
    checkOutput("rst_wait_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("post_rst_busy", busy, 1'b0);
    checkOutput("post_rst_txn", txn_count, 16'h0000);

    // Counter wrap: preload near the top, then issue writes across the wrap.
    txn_check_en = 1'b0;
    force dut.txn_count = 16'hFFF0;
    model_txn = 16'hFFF0;
    @(negedge clk);
    release dut.txn_count;
    @(negedge clk);
    txn_check_en = 1'b1;
    checkOutput("txn_preset", txn_count, 16'hFFF0);
    for (int n = 0; n < 20; n++)
      applyStimulus(1'b1, rand_addr(), $urandom);
    waitIdle();
    checkOutput("txn_wrap", txn_count, 16'h0004);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
